control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, with ports as listed below.
REQ-002 Clock  in  1  rising-edge clock for all state.
REQ-003 clear  in  1  synchronous active-low reset.
REQ-004 IR  in  32  instruction register contents from datapath; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
REQ-005 Mdone  in  1  memory read complete; 1 = Mdatain valid this cycle.
REQ-006 Stop  in  1  halt request, sampled only in T5.
REQ-007 PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Yin  out  1 each  datapath strobes, same meaning as datapath ports.
REQ-008 Rin  out  16  one-hot register-load enables, bit n drives RnIn.
REQ-009 Rout  out  16  one-hot register-drive enables, bit n drives Rnout.
REQ-010 opcode  out  5  ALU operation select.
REQ-011 Run  out  1  1 while executing; 0 in RESET_S and HALT_S.
REQ-012 Fault  out  1  sticky illegal-opcode flag.

Function
REQ-013 States SHALL be RESET_S, T0, T1, T2, T3, T4, T5, HALT_S; all outputs are Moore functions of state, plus IR fields in T3–T5.
REQ-014 RESET_S: all strobes, Rin, Rout and opcode 0; next state T0 unconditionally.
REQ-015 T0: PCout=MARin=IncPC=Zin=1; next T1.
REQ-016 T1: Zlowout=PCin=Read=MDRin=1, held every cycle while Mdone=0; next T2 on the first cycle with Mdone=1; no timeout.
REQ-017 T2: MDRout=IRin=1; next T3.
REQ-018 T3, ALU class (opcode 00011–01010 inclusive): Rout[Rb]=1 and Yin=1; next T4.
REQ-019 T3, opcode 11010 (nop): no strobes; next T0.
REQ-020 T3, opcode 11011 (halt): no strobes; next HALT_S.
REQ-021 T3, any other opcode: no strobes; Fault set to 1; next HALT_S.
REQ-022 T4: Rout[Rc]=1, Zin=1, opcode=IR[31:27]; next T5.
REQ-023 opcode SHALL be 00000 in every state other than T4.
REQ-024 T5: Zlowout=1 and Rin[Ra]=1; next HALT_S if Stop=1, else T0.
REQ-025 Ra=Rb=Rc (including R0) SHALL be legal and SHALL decode normally.
REQ-026 HALT_S: all strobes 0 and Run=0; held until reset.
REQ-027 At most one Rin bit and one Rout bit SHALL be 1 in any cycle.
REQ-028 Rin and Rout SHALL never both be nonzero in the same cycle.
REQ-029 Run=1 in T0–T5.
REQ-030 IR changes outside T3–T5 SHALL have no effect.

Reset
REQ-031 On a rising Clock edge with clear=0, the state SHALL become RESET_S from any state, including mid-instruction (T1 waiting, T4) and HALT_S.
REQ-032 On that same edge Fault SHALL clear to 0; all outputs are 0 in RESET_S.
REQ-033 clear=0 SHALL take priority over Mdone and Stop.
REQ-034 The first cycle after clear returns to 1 SHALL be RESET_S; T0 follows on the next edge.

Verification
REQ-035 IR=0x18918000 (add R1,R2,R3), Mdone=1 in T1, Stop=0 -> T0..T5 in 6 cycles; T3 Rout=0x0004 with Yin; T4 Rout=0x0008 with opcode=00011; T5 Rin=0x0002 with Zlowout; then T0.
REQ-036 Same instruction with Mdone held 0 for 3 cycles -> T1 strobes asserted for 4 cycles; T2 on cycle 5; remaining sequence unchanged.
REQ-037 IR opcode 11011 -> HALT_S after T3; Run=0; Fault=0; state held for 10+ cycles.
REQ-038 IR opcode 11111 -> HALT_S with Fault=1; Fault stays 1 until clear=0.
REQ-039 clear=0 asserted during T4 -> next edge RESET_S with all outputs 0 and opcode=00000; T0 two edges after clear returns to 1.
REQ-040 Stop=1 sampled in T5 of add -> Rin=0x0002 still issued in T5, then HALT_S; Stop=1 in any other state ignored.

Source files
------------

// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch (T0-T2), decode (T3), ALU execute (T4-T5),
// with halt and sticky illegal-opcode fault.
module control_unit (
   input  logic        Clock,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        Mdone,
   input  logic        Stop,
   output logic        PCout,
   output logic        MARin,
   output logic        IncPC,
   output logic        Zin,
   output logic        Zlowout,
   output logic        PCin,
   output logic        Read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic [15:0] Rin,
   output logic [15:0] Rout,
   output logic [4:0]  opcode,
   output logic        Run,
   output logic        Fault
);

   typedef enum logic [2:0] {
      RESET_S, T0, T1, T2, T3, T4, T5, HALT_S
   } state_t;

   localparam logic [4:0] OP_ALU_LO = 5'b00011;
   localparam logic [4:0] OP_ALU_HI = 5'b01010;
   localparam logic [4:0] OP_NOP    = 5'b11010;
   localparam logic [4:0] OP_HALT   = 5'b11011;

   state_t     state, state_next;
   logic       fault_q;
   logic [4:0] ir_op;
   logic [3:0] ir_ra, ir_rb, ir_rc;
   logic       is_alu, is_nop, is_halt;
   logic       unused_ir_bits;

   assign ir_op = IR[31:27];
   assign ir_ra = IR[26:23];
   assign ir_rb = IR[22:19];
   assign ir_rc = IR[18:15];
   assign unused_ir_bits = ^IR[14:0];

   assign is_alu  = (ir_op >= OP_ALU_LO) && (ir_op <= OP_ALU_HI);
   assign is_nop  = (ir_op == OP_NOP);
   assign is_halt = (ir_op == OP_HALT);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clock) begin
      if (!clear) begin
         state   <= RESET_S;
         fault_q <= 1'b0;
      end else begin
         state <= state_next;
         if (state == T3 && !is_alu && !is_nop && !is_halt)
            fault_q <= 1'b1;
      end
   end

   assign Fault = fault_q;

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      state_next = state;
      PCout   = 1'b0;
      MARin   = 1'b0;
      IncPC   = 1'b0;
      Zin     = 1'b0;
      Zlowout = 1'b0;
      PCin    = 1'b0;
      Read    = 1'b0;
      MDRin   = 1'b0;
      MDRout  = 1'b0;
      IRin    = 1'b0;
      Yin     = 1'b0;
      Rin     = 16'h0000;
      Rout    = 16'h0000;
      opcode  = 5'b00000;
      Run     = 1'b0;

      case (state)
         RESET_S: state_next = T0;
         T0: begin
            Run   = 1'b1;
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
            state_next = T1;
         end
         T1: begin
            // Strobes stay up for the whole memory wait, including the Mdone cycle.
            Run     = 1'b1;
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
            if (Mdone) state_next = T2;
         end
         T2: begin
            Run    = 1'b1;
            MDRout = 1'b1;
            IRin   = 1'b1;
            state_next = T3;
         end
         T3: begin
            Run = 1'b1;
            if (is_alu) begin
               Rout = 16'h0001 << ir_rb;
               Yin  = 1'b1;
               state_next = T4;
            end else if (is_nop) begin
               state_next = T0;
            end else begin
               state_next = HALT_S;
            end
         end
         T4: begin
            Run    = 1'b1;
            Rout   = 16'h0001 << ir_rc;
            Zin    = 1'b1;
            opcode = ir_op;
            state_next = T5;
         end
         T5: begin
            Run     = 1'b1;
            Zlowout = 1'b1;
            Rin     = 16'h0001 << ir_ra;
            state_next = Stop ? HALT_S : T0;
         end
         HALT_S:  state_next = HALT_S;
         default: state_next = RESET_S;
      endcase
   end

endmodule
